// File: rtl/vx_perf_memsys_csr_pkg.sv
// Shared definitions for the memory-system perf-counter CSR block: counter index map and FSM states.
// Index 12 is only mapped when PERF_DCACHE_PREFETCH_EN is defined.
package vx_perf_memsys_csr_pkg;

  localparam int PERF_MEMSYS_NUM = 20;

  localparam logic [4:0] PERF_MEMSYS_IDX_ICACHE_READS        = 5'd0;
  localparam logic [4:0] PERF_MEMSYS_IDX_ICACHE_READ_MISSES  = 5'd1;
  localparam logic [4:0] PERF_MEMSYS_IDX_ICACHE_PIPE_STALLS  = 5'd2;
  localparam logic [4:0] PERF_MEMSYS_IDX_ICACHE_CRSP_STALLS  = 5'd3;
  localparam logic [4:0] PERF_MEMSYS_IDX_DCACHE_READS        = 5'd4;
  localparam logic [4:0] PERF_MEMSYS_IDX_DCACHE_WRITES       = 5'd5;
  localparam logic [4:0] PERF_MEMSYS_IDX_DCACHE_READ_MISSES  = 5'd6;
  localparam logic [4:0] PERF_MEMSYS_IDX_DCACHE_WRITE_MISSES = 5'd7;
  localparam logic [4:0] PERF_MEMSYS_IDX_DCACHE_BANK_STALLS  = 5'd8;
  localparam logic [4:0] PERF_MEMSYS_IDX_DCACHE_MSHR_STALLS  = 5'd9;
  localparam logic [4:0] PERF_MEMSYS_IDX_DCACHE_PIPE_STALLS  = 5'd10;
  localparam logic [4:0] PERF_MEMSYS_IDX_DCACHE_CRSP_STALLS  = 5'd11;
  localparam logic [4:0] PERF_MEMSYS_IDX_DCACHE_PREFETCH     = 5'd12;
  localparam logic [4:0] PERF_MEMSYS_IDX_SMEM_READS          = 5'd13;
  localparam logic [4:0] PERF_MEMSYS_IDX_SMEM_WRITES         = 5'd14;
  localparam logic [4:0] PERF_MEMSYS_IDX_SMEM_BANK_STALLS    = 5'd15;
  localparam logic [4:0] PERF_MEMSYS_IDX_MEM_READS           = 5'd16;
  localparam logic [4:0] PERF_MEMSYS_IDX_MEM_WRITES          = 5'd17;
  localparam logic [4:0] PERF_MEMSYS_IDX_MEM_STALLS          = 5'd18;
  localparam logic [4:0] PERF_MEMSYS_IDX_MEM_LATENCY         = 5'd19;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } state_e;

endpackage

// File: rtl/vx_perf_memsys_csr_mux.sv
// 20:1 counter select; counters packed with index 0 in the low CTR_W bits.
// Config: PERF_DCACHE_PREFETCH_EN maps index 12; otherwise it reads as unmapped.
module vx_perf_memsys_csr_mux
  import vx_perf_memsys_csr_pkg::*;
#(
  parameter int CTR_W = 44
) (
  input  logic [4:0]                       i_idx,
  input  logic [PERF_MEMSYS_NUM*CTR_W-1:0] i_counters,
  output logic [CTR_W-1:0]                 o_value,
  output logic                             o_mapped
);

  always_comb begin
    o_value  = '0;
    o_mapped = 1'b0;
    if (int'(i_idx) < PERF_MEMSYS_NUM) begin
      o_mapped = 1'b1;
      o_value  = i_counters[int'(i_idx)*CTR_W +: CTR_W];
    end
`ifdef PERF_DCACHE_PREFETCH_EN
`else
    if (i_idx == PERF_MEMSYS_IDX_DCACHE_PREFETCH) begin
      o_mapped = 1'b0;
      o_value  = '0;
    end
`endif
  end

endmodule

// File: rtl/vx_perf_memsys_csr.sv
// CSR read port for memory-system perf counters: 1-cycle response, one request per 2 cycles.
// Lo reads snapshot the full counter so the following hi read is coherent; see PERF_DCACHE_PREFETCH_EN in the mux.
module vx_perf_memsys_csr
  import vx_perf_memsys_csr_pkg::*;
#(
  parameter int CTR_W = 44
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [PERF_MEMSYS_NUM*CTR_W-1:0] i_perf_memsys,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic [4:0]                       i_req_idx,
  input  logic                             i_req_hi,
  output logic                             o_rsp_valid,
  input  logic                             i_rsp_ready,
  output logic [31:0]                      o_rsp_data,
  output logic                             o_rsp_err
);

  state_e           r_state;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_err;
  logic [CTR_W-1:0] r_snap;
  logic [4:0]       r_snap_idx;
  logic             r_snap_vld;

  logic [CTR_W-1:0] w_live;
  logic             w_mapped;
  logic             w_accept;
  logic             w_snap_hit;
  logic [CTR_W-1:0] w_hi_src;
  logic [31:0]      w_hi_word;

  vx_perf_memsys_csr_mux #(.CTR_W(CTR_W)) u_mux (
    .i_idx      (i_req_idx),
    .i_counters (i_perf_memsys),
    .o_value    (w_live),
    .o_mapped   (w_mapped)
  );

  assign w_accept   = i_req_valid && (r_state == ST_IDLE);
  assign w_snap_hit = r_snap_vld && (r_snap_idx == i_req_idx);
  assign w_hi_src   = w_snap_hit ? r_snap : w_live;
  assign w_hi_word  = 32'(w_hi_src >> 32);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_snap     <= '0;
      r_snap_idx <= '0;
      r_snap_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_RSP;
            // Unmapped reads leave the snapshot untouched so a pending hi read stays coherent
            if (!w_mapped) begin
              r_rsp_data <= '0;
              r_rsp_err  <= 1'b1;
            end else if (!i_req_hi) begin
              r_rsp_data <= w_live[31:0];
              r_rsp_err  <= 1'b0;
              r_snap     <= w_live;
              r_snap_idx <= i_req_idx;
              r_snap_vld <= 1'b1;
            end else begin
              r_rsp_data <= w_hi_word;
              r_rsp_err  <= 1'b0;
              r_snap_vld <= 1'b0;
            end
          end
        end
        ST_RSP: begin
          if (i_rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_rsp_valid = (r_state == ST_RSP);
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_vx_perf_memsys_csr.sv
// Randomized bench for vx_perf_memsys_csr against a lo/hi snapshot reference model.
module tb_vx_perf_memsys_csr;
  localparam int CTR_W = 44;
  localparam int NUM   = 20;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM*CTR_W-1:0] perf_bus;
  logic                 req_valid;
  logic                 req_ready;
  logic [4:0]           req_idx;
  logic                 req_hi;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_data;
  logic                 rsp_err;

  logic [63:0] cnt [NUM];

  // Reference model state: the value captured by the last lo read, if still live
  logic [63:0] m_snap;
  int          m_snap_idx;
  bit          m_snap_vld;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_data;
  logic        exp_err;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM; g++) begin : g_pack
    assign perf_bus[g*CTR_W +: CTR_W] = cnt[g][CTR_W-1:0];
  end

  vx_perf_memsys_csr #(.CTR_W(CTR_W)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_perf_memsys (perf_bus),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_idx     (req_idx),
    .i_req_hi      (req_hi),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_data    (rsp_data),
    .o_rsp_err     (rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ctr_mask();
    return (CTR_W >= 64) ? '1 : ((64'd1 << CTR_W) - 64'd1);
  endfunction

  function automatic bit is_mapped(input int idx);
`ifdef PERF_DCACHE_PREFETCH_EN
    return idx < NUM;
`else
    return (idx < NUM) && (idx != 12);
`endif
  endfunction

  // Apply the read rules to the model at acceptance time
  task automatic model_read(input int idx, input bit hi);
    logic [63:0] live;
    logic [63:0] src;
    live = (idx < NUM) ? (cnt[idx] & ctr_mask()) : 64'd0;
    if (!is_mapped(idx)) begin
      exp_data = 32'd0;
      exp_err  = 1'b1;
    end else if (!hi) begin
      exp_data   = live[31:0];
      exp_err    = 1'b0;
      m_snap     = live;
      m_snap_idx = idx;
      m_snap_vld = 1'b1;
    end else begin
      src        = (m_snap_vld && m_snap_idx == idx) ? m_snap : live;
      src        = src >> 32;
      exp_data   = src[31:0];
      exp_err    = 1'b0;
      m_snap_vld = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_snap     = 64'd0;
    m_snap_idx = 0;
    m_snap_vld = 1'b0;
  endtask

  task automatic start_read(input int idx, input bit hi);
    @(negedge clk);
    chk("req_rdy_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_idx   = 5'(idx);
    req_hi    = hi;
    rsp_ready = 1'b0;
    model_read(idx, hi);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rsp_vld_lat1", rsp_valid, 1'b1);
    chk($sformatf("rsp_data[%0d,%0d]", idx, hi), rsp_data, exp_data);
    chk($sformatf("rsp_err[%0d,%0d]", idx, hi), rsp_err, exp_err);
    chk("req_rdy_busy", req_ready, 1'b0);
  endtask

  task automatic finish_read(input int hold);
    for (int i = 0; i < hold; i++) begin
      cnt[$urandom_range(NUM-1)] = {$urandom, $urandom};
      @(negedge clk);
      chk("hold_vld", rsp_valid, 1'b1);
      chk("hold_data", rsp_data, exp_data);
      chk("hold_err", rsp_err, exp_err);
      chk("hold_rdy", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_vld_done", rsp_valid, 1'b0);
    chk("req_rdy_done", req_ready, 1'b1);
  endtask

  task automatic do_read(input int idx, input bit hi, input int hold);
    start_read(idx, hi);
    finish_read(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_idx   = '0;
    req_hi    = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM; i++) cnt[i] = 64'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_rsp_vld", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_req_rdy", req_ready, 1'b1);

    // dcache_reads lo read
    cnt[4] = 64'h0000_0012_3456_789A;
    do_read(4, 1'b0, 0);
    chk("idx4_lo", exp_data, 32'h3456_789A);
    do_read(4, 1'b1, 1);

    // lo/hi pair across a 32-bit carry
    cnt[19] = 64'h0_FFFF_FFFF;
    do_read(19, 1'b0, 0);
    cnt[19] = 64'h1_0000_0000;
    do_read(19, 1'b1, 0);
    do_read(19, 1'b1, 0);

    // unmapped read between lo and hi keeps the snapshot
    cnt[3] = 64'h0000_0ABC_0000_0001;
    do_read(3, 1'b0, 0);
    cnt[3] = 64'h0000_0DEF_0000_0002;
    do_read(25, 1'b0, 0);
    do_read(31, 1'b1, 0);
    do_read(3, 1'b1, 0);

    // long backpressure
    cnt[7] = 64'h0000_0555_AAAA_5555;
    do_read(7, 1'b0, 5);

    // prefetch counter
    cnt[12] = 64'd7;
    do_read(12, 1'b0, 0);
    do_read(12, 1'b1, 0);

    // lo to one index, lo to another, hi to the first reads live
    cnt[5]  = 64'h0000_0111_0000_0000;
    cnt[6]  = 64'h0000_0222_0000_0000;
    do_read(5, 1'b0, 0);
    do_read(6, 1'b0, 0);
    cnt[5]  = 64'h0000_0333_0000_0000;
    do_read(5, 1'b1, 0);

    // reset while a response is pending
    cnt[0] = 64'h0000_0F00_1234_0000;
    do_read(0, 1'b0, 0);
    start_read(9, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_vld", rsp_valid, 1'b0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_mid_rdy", req_ready, 1'b1);
    chk("rst_mid_data", rsp_data, 32'd0);
    cnt[9] = 64'h0000_0777_0000_0000;
    do_read(9, 1'b1, 0);

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      int idx;
      int sel;
      sel = $urandom_range(9);
      if (sel < 3) begin
        idx = $urandom_range(NUM-1);
        cnt[idx] = {$urandom, $urandom};
      end else if (sel == 3) begin
        idx = $urandom_range(NUM-1);
        cnt[idx] = {24'd0, 8'($urandom), 32'hFFFF_FFF0 + 32'($urandom_range(15))};
      end
      idx = ($urandom_range(7) == 0) ? $urandom_range(31) : $urandom_range(NUM-1);
      do_read(idx, 1'($urandom_range(1)), $urandom_range(2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vx_perf_memsys_csr.md
VX_PERF_MEMSYS_CSR -- requirements
Module: VX_perf_memsys_csr

Interface
REQ-001 SHALL have parameter CTR_W, default 44; counter width, equal to `PERF_CTR_BITS, legal 33..64.
REQ-002 SHALL have ports clk, reset, clocked by one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 perf_memsys_if  input (slave modport)  20 x CTR_W  memory-system counters.
REQ-006 req_valid  input  1  CSR read request valid.
REQ-007 req_ready  output  1  request accepted when valid && ready.
REQ-008 req_idx  input  5  counter index.
REQ-009 req_hi  input  1  0 = bits [31:0], 1 = bits [CTR_W-1:32] zero-extended.
REQ-010 rsp_valid  output  1  response valid.
REQ-011 rsp_ready  input  1  response consumed when valid && ready.
REQ-012 rsp_data  output  32  read data.
REQ-013 rsp_err  output  1  unmapped index.

Function
REQ-014 Index map SHALL be: 0 icache_reads, 1 icache_read_misses, 2 icache_pipe_stalls, 3 icache_crsp_stalls, 4 dcache_reads, 5 dcache_writes, 6 dcache_read_misses, 7 dcache_write_misses, 8 dcache_bank_stalls, 9 dcache_mshr_stalls, 10 dcache_pipe_stalls, 11 dcache_crsp_stalls, 12 dcache_prefetch_requests, 13 smem_reads, 14 smem_writes, 15 smem_bank_stalls, 16 mem_reads, 17 mem_writes, 18 mem_stalls, 19 mem_latency.
REQ-015 FSM SHALL have states IDLE and RSP; req_ready = (state == IDLE); reset state is IDLE.
REQ-016 In IDLE, an accepted request SHALL register rsp_data/rsp_err and move to RSP; rsp_valid SHALL rise the cycle after acceptance (1-cycle latency).
REQ-017 In RSP, rsp_valid, rsp_data and rsp_err SHALL hold stable until rsp_ready; on rsp_ready, return to IDLE (no back-to-back acceptance; max one request per 2 cycles).
REQ-018 A lo read (req_hi=0) of a mapped index SHALL capture the full CTR_W counter value into a snapshot register, record snap_idx and set snap_vld, all in the accept cycle.
REQ-019 A hi read SHALL return the snapshot upper bits if snap_vld && snap_idx == req_idx, otherwise the live upper bits.
REQ-020 A hi read SHALL clear snap_vld; a lo read to a different index SHALL overwrite the snapshot.
REQ-021 For an index >= 20 (or an unmapped index per REQ-026), the block SHALL return rsp_data = 0 and rsp_err = 1, leaving the snapshot unchanged.
REQ-022 Counter wrap (live value decreasing) SHALL need no special handling; the snapshot guarantees a coherent lo/hi pair across the wrap.

Reset
REQ-023 Reset SHALL force state = IDLE, rsp_valid = 0, rsp_data = 0, rsp_err = 0, snap_vld = 0, snap_idx = 0 and snapshot = 0.
REQ-024 Reset asserted in RSP SHALL drop the pending response with no rsp_valid in the following cycle; req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-025 Macro PERF_DCACHE_PREFETCH_EN defined: index 12 SHALL map to dcache_prefetch_requests.
REQ-026 Macro PERF_DCACHE_PREFETCH_EN undefined: index 12 SHALL be unmapped (rsp_err = 1, data 0), and the dcache_prefetch_requests input SHALL be ignored.

Structure
REQ-027 A shared package SHALL hold the index localparams (PERF_MEMSYS_IDX_*), PERF_MEMSYS_NUM = 20 and the FSM state enum.
REQ-028 The 20:1 counter mux SHALL be one sub-module, VX_perf_memsys_mux (inputs: index, counters; outputs: value, mapped).

Verification
REQ-029 Reset mid-RSP: reset asserted while rsp_valid=1 -> next cycle rsp_valid=0; the cycle after reset deasserts, req_ready=1.
REQ-030 Read idx 4 lo with dcache_reads=0x0000_0012_3456_789A -> rsp_data 0x3456789A, rsp_err 0, one cycle after acceptance.
REQ-031 Read idx 19 lo, counter increments from 0x0_FFFF_FFFF to 0x1_0000_0000 between lo and hi reads -> lo 0xFFFFFFFF, hi 0x0.
REQ-032 Read idx 25 -> rsp_err 1, rsp_data 0; subsequent hi read of the previously snapped index still returns the snapshot.
REQ-033 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout.
REQ-034 Read idx 12 with prefetch=7: macro defined -> data 7, err 0; macro undefined -> data 0, err 1.
